async_fifo_gray: RTL and testbench

- Parametrised dual-clock FIFO. Successor to the tag FIFO.
- Write and read sides run on independent clocks.
- Pointers cross domains as Gray code through multi-flop synchronisers.
- Adds registered full/empty, fill levels and programmable almost-full/almost-empty flags.
- Used for tag/result queues between pipeline blocks in different clock domains.

---
 rtl/async_fifo_pkg.sv | 26 ++
 rtl/async_fifo_gray_sync.sv | 29 ++
 rtl/async_fifo_gray.sv | 148 ++++++++++++++
 tb/tb_async_fifo_gray.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock Gray-pointer FIFO.
// Helpers take pointers zero-extended to PTR_MAX_W bits, so any pointer width up to that works.
package async_fifo_pkg;

    localparam int unsigned DSIZE_DFLT = 5;
    localparam int unsigned ASIZE_DFLT = 5;
    localparam int unsigned DEPTH      = 1 << ASIZE_DFLT;
    localparam int unsigned PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = '0;
        for (int i = 0; i < int'(PTR_MAX_W); i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into clk_i's domain.
module gray_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FWFT FIFO with Gray pointer crossings, registered flags and fill levels.
// Define ASYNC_FIFO_ERR_EN to add sticky woverflow/runderflow outputs.
module async_fifo_gray
    import async_fifo_pkg::*;
#(
    parameter int unsigned DSIZE       = DSIZE_DFLT,
    parameter int unsigned ASIZE       = ASIZE_DFLT,
    parameter int unsigned AFULL_THR   = 28,
    parameter int unsigned AEMPTY_THR  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic             woverflow,
    output logic             runderflow
`endif
);

    localparam int unsigned PW        = ASIZE + 1;
    localparam int unsigned MEM_DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [MEM_DEPTH];

    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d;
    logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d;
    logic [PW-1:0] rgray_wsync, wgray_rsync;
    logic          wfull_q, wfull_d, wafull_q, wafull_d, wen_c;
    logic          rempty_q, rempty_d, raempty_q, raempty_d, ren_c;

    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_w2r_sync (
        .clk_i   (rclk),
        .rst_n_i (rrst_n),
        .d_i     (wgray_q),
        .q_o     (wgray_rsync)
    );

    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_r2w_sync (
        .clk_i   (wclk),
        .rst_n_i (wrst_n),
        .d_i     (rgray_q),
        .q_o     (rgray_wsync)
    );

    // Write side: full when the next write pointer sits exactly one lap ahead of the synced read pointer.
    always_comb begin
        wen_c    = winc && !wfull_q;
        wbin_d   = wbin_q + PW'(wen_c);
        wgray_d  = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
        wfull_d  = (wgray_d == {~rgray_wsync[ASIZE:ASIZE-1], rgray_wsync[ASIZE-2:0]});
        wlevel_d = wbin_d - PW'(gray2bin(PTR_MAX_W'(rgray_wsync)));
        wafull_d = (PTR_MAX_W'(wlevel_d) >= PTR_MAX_W'(AFULL_THR));
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= (AFULL_THR == 0);
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wen_c) begin
            mem[wbin_q[ASIZE-1:0]] <= wdata;
        end
    end

    // Read side: empty when the next read pointer catches the synced write pointer.
    always_comb begin
        ren_c     = rinc && !rempty_q;
        rbin_d    = rbin_q + PW'(ren_c);
        rgray_d   = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
        rempty_d  = (rgray_d == wgray_rsync);
        rlevel_d  = PW'(gray2bin(PTR_MAX_W'(wgray_rsync))) - rbin_d;
        raempty_d = (PTR_MAX_W'(rlevel_d) <= PTR_MAX_W'(AEMPTY_THR));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rgray_q   <= '0;
            rlevel_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
        end else begin
            rbin_q    <= rbin_d;
            rgray_q   <= rgray_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
        end
    end

    assign rdata         = mem[rbin_q[ASIZE-1:0]];
    assign wfull         = wfull_q;
    assign walmost_full  = wafull_q;
    assign wlevel        = wlevel_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = raempty_q;
    assign rlevel        = rlevel_q;

`ifdef ASYNC_FIFO_ERR_EN
    logic woverflow_q, runderflow_q;

    // Sticky request-while-blocked indicators, cleared only by their own domain reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow_q <= 1'b0;
        end else if (winc && wfull_q) begin
            woverflow_q <= 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow_q <= 1'b0;
        end else if (rinc && rempty_q) begin
            runderflow_q <= 1'b1;
        end
    end

    assign woverflow  = woverflow_q;
    assign runderflow = runderflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed bench for async_fifo_gray: reset, latency, fill/drain, thresholds, mid-stream reset, clock-ratio stress.
`timescale 1ns/1ps
module tb_async_fifo_gray;

    localparam int unsigned DSIZE = 5;
    localparam int unsigned ASIZE = 5;
    localparam int          DEPTH = 32;

    logic             wclk = 1'b0;
    logic             rclk = 1'b0;
    logic             wrst_n, rrst_n, winc, rinc;
    logic [DSIZE-1:0] wdata, rdata;
    logic             wfull, walmost_full, rempty, ralmost_empty;
    logic [ASIZE:0]   wlevel, rlevel;
`ifdef ASYNC_FIFO_ERR_EN
    logic             woverflow, runderflow;
`endif

    int      errors = 0;
    int      checks = 0;
    realtime whalf  = 5.0;
    realtime rhalf  = 13.513;
    bit      rclk_en = 1'b1;

    initial forever begin #(whalf); wclk = ~wclk; end
    initial forever begin #(rhalf); if (rclk_en) rclk = ~rclk; end

    async_fifo_gray #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_THR(28), .AEMPTY_THR(4), .SYNC_STAGES(2)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rdata(rdata),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel)
`ifdef ASYNC_FIFO_ERR_EN
        , .woverflow(woverflow), .runderflow(runderflow)
`endif
    );

    task automatic push(input logic [DSIZE-1:0] d);
        @(negedge wclk); winc = 1'b1; wdata = d;
        @(negedge wclk); winc = 1'b0;
    endtask

    task automatic pop();
        @(negedge rclk); rinc = 1'b1;
        @(negedge rclk); rinc = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge wclk);
        repeat (4) @(negedge rclk);
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; rrst_n = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        repeat (4) @(negedge rclk);
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %b expected 0", wfull); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_walmost_full: got %b expected 0", walmost_full); end
        checks++; if (wlevel !== 6'd0) begin errors++; $display("FAIL reset_wlevel: got %0d expected 0", wlevel); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
        checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_ralmost_empty: got %b expected 1", ralmost_empty); end
        checks++; if (rlevel !== 6'd0) begin errors++; $display("FAIL reset_rlevel: got %0d expected 0", rlevel); end
        wrst_n = 1'b1; rrst_n = 1'b1;
        settle();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL post_reset_rempty: got %b expected 1", rempty); end
    endtask

    task automatic test_empty_latency();
        int n;
        n = 0;
        fork
            push(5'h15);
            begin
                wait (winc === 1'b1);
                @(posedge wclk);
                while (rempty === 1'b1 && n < 10) begin
                    @(posedge rclk); #1; n++;
                end
                checks++; if (n !== 3) begin errors++; $display("FAIL empty_latency_edges: got %0d expected 3", n); end
                checks++; if (rdata !== 5'h15) begin errors++; $display("FAIL empty_latency_rdata: got %h expected 15", rdata); end
                checks++; if (rlevel !== 6'd1) begin errors++; $display("FAIL empty_latency_rlevel: got %0d expected 1", rlevel); end
            end
        join
        checks++; if (wlevel !== 6'd1) begin errors++; $display("FAIL empty_latency_wlevel: got %0d expected 1", wlevel); end
        pop();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL empty_latency_drain: got %b expected 1", rempty); end
    endtask

    task automatic test_fill();
        int n, m;
        n = 0; m = 0;
        settle();
        @(negedge rclk); rclk_en = 1'b0;
        for (int i = 0; i < 33; i++) begin
            push(DSIZE'(i));
            if (i == 30) begin
                checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL fill31_wfull: got %b expected 0", wfull); end
                checks++; if (wlevel !== 6'd31) begin errors++; $display("FAIL fill31_wlevel: got %0d expected 31", wlevel); end
            end
            if (i == 31) begin
                checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill32_wfull: got %b expected 1", wfull); end
                checks++; if (wlevel !== 6'd32) begin errors++; $display("FAIL fill32_wlevel: got %0d expected 32", wlevel); end
            end
        end
        checks++; if (wlevel !== 6'd32) begin errors++; $display("FAIL fill33_ignored_wlevel: got %0d expected 32", wlevel); end
        rclk_en = 1'b1;
        while (rempty === 1'b1 && n < 20) begin @(negedge rclk); n++; end
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty_fall: got %b expected 0", rempty); end
        checks++; if (rdata !== 5'd0) begin errors++; $display("FAIL fill_rdata0: got %0d expected 0", rdata); end
        fork
            pop();
            begin
                wait (rinc === 1'b1);
                @(posedge rclk);
                while (wfull === 1'b1 && m < 10) begin
                    @(posedge wclk); #1; m++;
                end
                checks++; if (m !== 3) begin errors++; $display("FAIL full_release_edges: got %0d expected 3", m); end
            end
        join
        for (int i = 1; i < 32; i++) begin
            checks++; if (rdata !== DSIZE'(i)) begin errors++; $display("FAIL fill_order[%0d]: got %0d expected %0d", i, rdata, i); end
            if (i == 31) begin
                checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_last_rempty: got %b expected 0", rempty); end
            end
            pop();
        end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL fill_drained_rempty: got %b expected 1", rempty); end
        checks++; if (rlevel !== 6'd0) begin errors++; $display("FAIL fill_drained_rlevel: got %0d expected 0", rlevel); end
    endtask

    task automatic test_thresholds();
        settle();
        for (int i = 0; i < 27; i++) push(DSIZE'(i));
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL thr27_walmost_full: got %b expected 0", walmost_full); end
        checks++; if (wlevel !== 6'd27) begin errors++; $display("FAIL thr27_wlevel: got %0d expected 27", wlevel); end
        push(5'd27);
        checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL thr28_walmost_full: got %b expected 1", walmost_full); end
        settle();
        checks++; if (rlevel !== 6'd28) begin errors++; $display("FAIL thr28_rlevel: got %0d expected 28", rlevel); end
        checks++; if (ralmost_empty !== 1'b0) begin errors++; $display("FAIL thr28_ralmost_empty: got %b expected 0", ralmost_empty); end
        for (int i = 0; i < 23; i++) begin
            checks++; if (rdata !== DSIZE'(i)) begin errors++; $display("FAIL thr_order[%0d]: got %0d expected %0d", i, rdata, i); end
            pop();
        end
        checks++; if (rlevel !== 6'd5) begin errors++; $display("FAIL thr5_rlevel: got %0d expected 5", rlevel); end
        checks++; if (ralmost_empty !== 1'b0) begin errors++; $display("FAIL thr5_ralmost_empty: got %b expected 0", ralmost_empty); end
        pop();
        checks++; if (rlevel !== 6'd4) begin errors++; $display("FAIL thr4_rlevel: got %0d expected 4", rlevel); end
        checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL thr4_ralmost_empty: got %b expected 1", ralmost_empty); end
    endtask

    task automatic test_reset_midstream();
        int n;
        n = 0;
        for (int i = 0; i < 13; i++) push(DSIZE'(8 + i));
        checks++; if (wlevel !== 6'd17) begin errors++; $display("FAIL mid_held_wlevel: got %0d expected 17", wlevel); end
        wrst_n = 1'b0; rrst_n = 1'b0;
        repeat (4) @(negedge rclk);
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL mid_wfull: got %b expected 0", wfull); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mid_rempty: got %b expected 1", rempty); end
        checks++; if (wlevel !== 6'd0) begin errors++; $display("FAIL mid_wlevel: got %0d expected 0", wlevel); end
        checks++; if (rlevel !== 6'd0) begin errors++; $display("FAIL mid_rlevel: got %0d expected 0", rlevel); end
        wrst_n = 1'b1; rrst_n = 1'b1;
        settle();
        push(5'h0A);
        while (rempty === 1'b1 && n < 10) begin @(negedge rclk); n++; end
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL mid_after_rempty: got %b expected 0", rempty); end
        checks++; if (rdata !== 5'h0A) begin errors++; $display("FAIL mid_first_word: got %h expected 0a", rdata); end
        checks++; if (rlevel !== 6'd1) begin errors++; $display("FAIL mid_after_rlevel: got %0d expected 1", rlevel); end
        pop();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mid_drain_rempty: got %b expected 1", rempty); end
    endtask

`ifdef ASYNC_FIFO_ERR_EN
    task automatic test_err();
        int n;
        n = 0;
        settle();
        checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL err_init_woverflow: got %b expected 0", woverflow); end
        for (int i = 0; i < 32; i++) push(DSIZE'(i));
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL err_full: got %b expected 1", wfull); end
        push(5'h11);
        checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL err_woverflow: got %b expected 1", woverflow); end
        checks++; if (wlevel !== 6'd32) begin errors++; $display("FAIL err_overflow_wlevel: got %0d expected 32", wlevel); end
        settle();
        for (int i = 0; i < 32; i++) begin
            checks++; if (rdata !== DSIZE'(i)) begin errors++; $display("FAIL err_order[%0d]: got %0d expected %0d", i, rdata, i); end
            pop();
        end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL err_drained: got %b expected 1", rempty); end
        checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL err_woverflow_sticky: got %b expected 1", woverflow); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL err_init_runderflow: got %b expected 0", runderflow); end
        pop();
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL err_runderflow: got %b expected 1", runderflow); end
        checks++; if (rlevel !== 6'd0) begin errors++; $display("FAIL err_underflow_rlevel: got %0d expected 0", rlevel); end
        push(5'h07);
        while (rempty === 1'b1 && n < 10) begin @(negedge rclk); n++; end
        checks++; if (rdata !== 5'h07) begin errors++; $display("FAIL err_after_underflow_rdata: got %h expected 07", rdata); end
        pop();
        wrst_n = 1'b0; rrst_n = 1'b0;
        repeat (4) @(negedge rclk);
        checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL err_woverflow_clear: got %b expected 0", woverflow); end
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL err_runderflow_clear: got %b expected 0", runderflow); end
        wrst_n = 1'b1; rrst_n = 1'b1;
        settle();
    endtask
`endif

    task automatic test_clock_ratio(input int n_words, input realtime wh, input realtime rh);
        int wcnt, rcnt;
        whalf = wh; rhalf = rh;
        settle();
        wcnt = 0; rcnt = 0;
        fork
            begin
                int  it;
                bit  wr_go;
                it = 0;
                while (wcnt < n_words && it < 40 * n_words) begin
                    @(negedge wclk); it++;
                    winc  = ($urandom_range(0, 3) != 0);
                    wdata = DSIZE'(wcnt);
                    checks++; if (!wfull && (wcnt - rcnt) >= DEPTH) begin errors++; $display("FAIL stress_not_full: got occupancy %0d expected < %0d", wcnt - rcnt, DEPTH); end
                    checks++; if (int'(wlevel) < wcnt - rcnt) begin errors++; $display("FAIL stress_wlevel: got %0d expected >= %0d", wlevel, wcnt - rcnt); end
                    wr_go = winc && !wfull;
                    @(posedge wclk);
                    if (wr_go) wcnt++;
                end
                @(negedge wclk); winc = 1'b0;
            end
            begin
                int  it;
                bit  rd_go;
                it = 0;
                while (rcnt < n_words && it < 40 * n_words) begin
                    @(negedge rclk); it++;
                    rinc  = ($urandom_range(0, 3) != 0);
                    rd_go = rinc && !rempty;
                    checks++; if (!rempty && wcnt == rcnt) begin errors++; $display("FAIL stress_not_empty: got occupancy %0d expected > 0", wcnt - rcnt); end
                    checks++; if (int'(rlevel) > wcnt - rcnt) begin errors++; $display("FAIL stress_rlevel: got %0d expected <= %0d", rlevel, wcnt - rcnt); end
                    if (rd_go) begin
                        checks++; if (rdata !== DSIZE'(rcnt)) begin errors++; $display("FAIL stress_data[%0d]: got %0d expected %0d", rcnt, rdata, DSIZE'(rcnt)); end
                    end
                    @(posedge rclk);
                    if (rd_go) rcnt++;
                end
                @(negedge rclk); rinc = 1'b0;
            end
        join
        checks++; if (wcnt !== n_words) begin errors++; $display("FAIL stress_writes: got %0d expected %0d", wcnt, n_words); end
        checks++; if (rcnt !== n_words) begin errors++; $display("FAIL stress_reads: got %0d expected %0d", rcnt, n_words); end
        settle();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL stress_end_rempty: got %b expected 1", rempty); end
    endtask

    initial begin
        test_reset();
        test_empty_latency();
        test_fill();
        test_thresholds();
        test_reset_midstream();
`ifdef ASYNC_FIFO_ERR_EN
        test_err();
`endif
        test_clock_ratio(2500, 5.0, 13.513);
        test_clock_ratio(2500, 13.513, 5.0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion before 3 ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
